ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit sitting between the PC stage and decode. Owns the fetch PC, issues word-aligned requests to instruction memory over a valid/ready channel, matches in-order responses to their PCs, and buffers {pc, instr} pairs for decode behind a valid/ready handshake. Redirects (taken jumps/branches) flush buffered and in-flight fetches.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset
- DEPTH, 4, output-buffer entries and maximum in-flight requests (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect  in  1  discard all fetched/in-flight work, restart at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 00)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  request address (word aligned)
- imem_rsp_valid  in  1  response valid; in request order, latency ≥1, no backpressure
- imem_rsp_data  in  32  instruction word
- id_valid  out  1  buffer head valid
- id_ready  in  1  decode accepts head
- id_pc  out  32  PC of head instruction
- id_instr  out  32  head instruction word

## Operation

- State: fetch_pc, in-flight PC queue (DEPTH), output buffer (DEPTH), inflight count, drop count (0..DEPTH).
- Issue: imem_req_valid = !rst && !redirect && (inflight + drop + occ < DEPTH), all from registered state; imem_req_addr = fetch_pc.
- Accept (valid && ready): push fetch_pc into PC queue, inflight++, fetch_pc += 4 mod 2^32 (0xFFFF_FFFC wraps to 0).
- Response with drop > 0: discarded, drop--. Otherwise: pop PC queue, push {pc, data} into output buffer, inflight--.
- Decode: id_valid = occ != 0; id_pc/id_instr = head; pop on id_valid && id_ready.
- Redirect cycle: fetch_pc <= {redirect_pc[31:2], 2'b00}; output buffer and PC queue cleared; drop <= drop + inflight − (1 if response arrives this cycle); inflight <= 0; no request issued.
- Simultaneous events: id handshake in redirect cycle completes (decode consumed it), then flush; response in redirect cycle is discarded; push and pop same cycle on output buffer both take effect; credit rule guarantees no overflow.
- imem_req_valid, once high, holds with stable address until accepted, except it drops on redirect or rst.
- Responses with inflight = 0 and drop = 0 are protocol errors (assertion, ignored by RTL).

## Timing

- Reset values: fetch_pc = RESET_PC, inflight = drop = occ = 0; imem_req_valid = 0 and id_valid = 0 while rst high.
- First request: cycle after rst deasserts, addr = RESET_PC.
- Latency: request accepted cycle T, response T+L, id_valid from T+L+1.
- Throughput: 1 instr/cycle with L = 1, DEPTH = 4, id_ready held high.
- Redirect at cycle R: request at redirect_pc earliest R+1; id_valid 0 in R+1 until new responses arrive.
- No combinational path from id_ready or imem_rsp_valid to imem_req_valid.

## Structure

- Shared definitions header: fetch entry struct typedef {pc[31:0], instr[31:0]}, RESET_PC default, INSTR_BYTES = 4.
- Sub-module fetch_fifo: parameterised synchronous FIFO (width, depth, push, pop, flush, count, head), instantiated for the PC queue and the output buffer.

## Test plan

- Reset, imem ready always, L = 1, id_ready = 1 -> requests 0x0, 0x4, 0x8 on consecutive cycles; id_pc 0x0 with its data first seen 2 cycles after first accept; one instr per cycle thereafter.
- id_ready = 0 for 10 cycles -> at most 4 requests outstanding+buffered; imem_req_valid low; release yields in-order pcs 0x0..0xC, nothing lost.
- Redirect to 0x103 with 2 requests in flight -> next request addr 0x100; 2 stale responses dropped; first id_pc = 0x100.
- Redirect in same cycle as response and id handshake -> handshake counted, response discarded, buffer empty next cycle.
- RESET_PC = 0xFFFF_FFF8 -> request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- imem_req_ready low 5 cycles -> imem_req_valid and addr stable throughout; rst asserted mid-stall -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: buffered entry layout,
// default reset PC and instruction size.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response channel plus the decode-side handshake.
// master is the fetch unit, slave is the surrounding memory/decode logic.
interface ifetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and head-of-queue output.
// Push and pop in the same cycle both take effect; flush wins over both.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the fetch PC, issues in-order word fetches,
// pairs responses with their PCs and buffers them for decode; redirects flush.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  ifetch_if.master    bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] inflight, occ;
  logic [CW+1:0] used;
  logic          accept, rsp_live, id_pop;
  logic [31:0]   pcq_head;
  fetch_entry_t  ob_wdata, ob_head;

  // Credits cover in-flight, to-be-dropped and buffered entries, so a
  // response always finds room in the output buffer.
  always_comb begin
    used = (CW+2)'(inflight) + (CW+2)'(drop_q) + (CW+2)'(occ);
    bus.imem_req_valid = !rst && !redirect && (used < (CW+2)'(DEPTH));
    bus.imem_req_addr  = fetch_pc_q;
    accept   = bus.imem_req_valid && bus.imem_req_ready;
    rsp_live = bus.imem_rsp_valid && (drop_q == '0) && (inflight != '0) && !redirect;
    id_pop   = bus.id_valid && bus.id_ready;
    ob_wdata = '{pc: pcq_head, instr: bus.imem_rsp_data};
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)    fetch_pc_d = word_align(redirect_pc);
    else if (accept) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
  end

  // On redirect every outstanding request becomes a response to discard,
  // less the one (stale or live) being consumed this very cycle.
  always_comb begin
    drop_d = drop_q;
    if (redirect) begin
      if (bus.imem_rsp_valid && ((drop_q != '0) || (inflight != '0)))
        drop_d = drop_q + inflight - CW'(1);
      else
        drop_d = drop_q + inflight;
    end else if (bus.imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (accept),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_live),
    .count_o (inflight),
    .head_o  (pcq_head)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (rsp_live),
    .wdata_i (ob_wdata),
    .pop_i   (id_pop),
    .count_o (occ),
    .head_o  (ob_head)
  );

  always_comb begin
    bus.id_valid = !rst && (occ != '0);
    bus.id_pc    = ob_head.pc;
    bus.id_instr = ob_head.instr;
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> ((inflight != '0) || (drop_q != '0)));

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: in-order memory model with configurable
// latency/readiness, scenario tasks and a randomized stream check.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  int n_checks = 0;
  int n_fail   = 0;

  int mem_mode = 0;  // 0 always ready, 1 never ready, 2 random
  int lat_min  = 1;
  int lat_max  = 1;
  int cyc      = 0;

  ifetch_if mif ();
  ifetch_if wif ();

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .bus(mif.master)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(32'h0), .bus(wif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: observe at negedge, act after the following posedge.
  logic        s_acc, s_rst;
  logic [31:0] s_addr;
  int          s_mode, s_lmin, s_lmax, due;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always begin
    @(negedge clk);
    s_acc  = mif.imem_req_valid && mif.imem_req_ready;
    s_addr = mif.imem_req_addr;
    s_rst  = rst;
    s_mode = mem_mode;
    s_lmin = lat_min;
    s_lmax = lat_max;
    @(posedge clk);
    cyc++;
    if (s_rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (s_acc) begin
      due = cyc - 1 + int'($urandom_range(s_lmax, s_lmin));
      if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
      pend_addr.push_back(s_addr);
      pend_due.push_back(due);
    end
    #1;
    if (!s_rst && pend_due.size() > 0 && pend_due[0] == cyc) begin
      mif.imem_rsp_valid = 1'b1;
      mif.imem_rsp_data  = memf(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mif.imem_rsp_valid = 1'b0;
      mif.imem_rsp_data  = $urandom;
    end
    if (s_mode == 0)      mif.imem_req_ready = 1'b1;
    else if (s_mode == 1) mif.imem_req_ready = 1'b0;
    else                  mif.imem_req_ready = ($urandom_range(0, 99) < 70);
  end

  task automatic test_reset;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (mif.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", mif.imem_req_valid); end
      n_checks++;
      if (mif.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b expected 0", mif.id_valid); end
      n_checks++;
      if (wif.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_req_valid: got %b expected 0", wif.imem_req_valid); end
    end
  endtask

  task automatic test_stream;
    logic exp_idv;
    logic [31:0] exp_pc;
    @(posedge clk); #1;
    rst = 1'b0;
    mif.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 32'(4*i)) begin
        n_fail++; $display("FAIL stream_req[%0d]: got v=%b a=%h expected v=1 a=%h", i, mif.imem_req_valid, mif.imem_req_addr, 32'(4*i));
      end
      exp_idv = (i >= 2);
      n_checks++;
      if (mif.id_valid !== exp_idv) begin n_fail++; $display("FAIL stream_id_valid[%0d]: got %b expected %b", i, mif.id_valid, exp_idv); end
      if (exp_idv) begin
        exp_pc = 32'(4*(i-2));
        n_checks++;
        if (mif.id_pc !== exp_pc || mif.id_instr !== memf(exp_pc)) begin
          n_fail++; $display("FAIL stream_id[%0d]: got pc=%h ins=%h expected pc=%h ins=%h", i, mif.id_pc, mif.id_instr, exp_pc, memf(exp_pc));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int live = 0;
    int got = 0;
    logic [31:0] exp_pc = 32'h0;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0; mif.id_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_redirect_noreq: got %b expected 0", mif.imem_req_valid); end
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mif.imem_req_valid && mif.imem_req_ready) live++;
      n_checks++;
      if (live > 4) begin n_fail++; $display("FAIL bp_outstanding[%0d]: got %0d expected <=4", i, live); end
    end
    n_checks++;
    if (mif.imem_req_valid !== 1'b0 || live != 4) begin
      n_fail++; $display("FAIL bp_full: got v=%b live=%0d expected v=0 live=4", mif.imem_req_valid, live);
    end
    @(posedge clk); #1;
    mif.id_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mif.id_valid && mif.id_ready) begin
        n_checks++;
        if (mif.id_pc !== exp_pc || mif.id_instr !== memf(exp_pc)) begin
          n_fail++; $display("FAIL bp_order: got pc=%h ins=%h expected pc=%h ins=%h", mif.id_pc, mif.id_instr, exp_pc, memf(exp_pc));
        end
        exp_pc += 32'd4;
        got++;
      end
    end
    n_checks++;
    if (got < 4) begin n_fail++; $display("FAIL bp_release_count: got %0d expected >=4", got); end
  endtask

  task automatic test_redirect;
    logic found = 1'b0;
    @(posedge clk); #1;
    lat_min = 3; lat_max = 3;
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (!(mif.imem_req_valid && mif.imem_req_ready) || mif.imem_req_addr !== 32'(32'h200 + 4*i)) begin
        n_fail++; $display("FAIL redir_prefetch[%0d]: got v=%b a=%h expected accepted a=%h", i, mif.imem_req_valid, mif.imem_req_addr, 32'(32'h200 + 4*i));
      end
    end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    n_checks++;
    if (mif.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_noreq: got %b expected 0", mif.imem_req_valid); end
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_addr: got v=%b a=%h expected v=1 a=00000100", mif.imem_req_valid, mif.imem_req_addr);
    end
    n_checks++;
    if (mif.id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_id_empty: got %b expected 0", mif.id_valid); end
    for (int i = 0; i < 15 && !found; i++) begin
      @(negedge clk);
      if (mif.id_valid && mif.id_ready) begin
        found = 1'b1;
        n_checks++;
        if (mif.id_pc !== 32'h100 || mif.id_instr !== memf(32'h100)) begin
          n_fail++; $display("FAIL redir_first_pc: got pc=%h ins=%h expected pc=00000100 ins=%h", mif.id_pc, mif.id_instr, memf(32'h100));
        end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL redir_timeout: got no handshake expected one within 15 cycles"); end
  endtask

  task automatic test_redirect_collide;
    logic [31:0] exp_pc = 32'h300;
    logic found = 1'b0;
    @(posedge clk); #1;
    lat_min = 1; lat_max = 1;
    redirect = 1'b1; redirect_pc = 32'h300; mif.id_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mif.id_valid && mif.id_ready) begin
        n_checks++;
        if (mif.id_pc !== exp_pc) begin n_fail++; $display("FAIL collide_warm: got pc=%h expected %h", mif.id_pc, exp_pc); end
        exp_pc += 32'd4;
      end
    end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    n_checks++;
    if (mif.id_valid !== 1'b1 || mif.imem_rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL collide_setup: got id_valid=%b rsp_valid=%b expected 1 1", mif.id_valid, mif.imem_rsp_valid);
    end
    n_checks++;
    if (mif.id_pc !== exp_pc) begin n_fail++; $display("FAIL collide_hs_pc: got %h expected %h", mif.id_pc, exp_pc); end
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.id_valid !== 1'b0) begin n_fail++; $display("FAIL collide_empty: got %b expected 0", mif.id_valid); end
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mif.id_valid && mif.id_ready) begin
        found = 1'b1;
        n_checks++;
        if (mif.id_pc !== 32'h400) begin n_fail++; $display("FAIL collide_next_pc: got %h expected 00000400", mif.id_pc); end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL collide_timeout: got no handshake expected one within 10 cycles"); end
  endtask

  // Reference: fetch and decode streams are both consecutive words from the
  // last redirect target; live work never exceeds DEPTH entries.
  task automatic test_random;
    logic [31:0] exp_req = '0, exp_pc = '0, tgt, prev_addr = '0;
    logic do_redir, prev_pend = 1'b0;
    int hs_drain = 0;
    lat_min = 1; lat_max = 4; mem_mode = 2;
    for (int c = 0; c < 440; c++) begin
      @(posedge clk); #1;
      if (c == 400) begin mem_mode = 0; lat_min = 1; lat_max = 1; end
      do_redir = (c == 0) || (c < 400 && $urandom_range(0, 99) < 3);
      redirect = do_redir;
      redirect_pc = ((c % 5) == 4) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      tgt = redirect_pc;
      mif.id_ready = (c >= 400) || ($urandom_range(0, 99) < 70);
      @(negedge clk);
      if (do_redir) begin
        n_checks++;
        if (mif.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_noreq[%0d]: got %b expected 0", c, mif.imem_req_valid); end
      end else begin
        if (prev_pend) begin
          n_checks++;
          if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== prev_addr) begin
            n_fail++; $display("FAIL rnd_hold[%0d]: got v=%b a=%h expected v=1 a=%h", c, mif.imem_req_valid, mif.imem_req_addr, prev_addr);
          end
        end
        if (mif.imem_req_valid && mif.imem_req_ready) begin
          n_checks++;
          if (mif.imem_req_addr !== exp_req) begin n_fail++; $display("FAIL rnd_req_addr[%0d]: got %h expected %h", c, mif.imem_req_addr, exp_req); end
          exp_req += 32'd4;
        end
      end
      if (c > 0 && mif.id_valid && mif.id_ready) begin
        n_checks++;
        if (mif.id_pc !== exp_pc || mif.id_instr !== memf(exp_pc)) begin
          n_fail++; $display("FAIL rnd_id[%0d]: got pc=%h ins=%h expected pc=%h ins=%h", c, mif.id_pc, mif.id_instr, exp_pc, memf(exp_pc));
        end
        exp_pc += 32'd4;
        if (c >= 400) hs_drain++;
      end
      if (do_redir) begin
        exp_req = {tgt[31:2], 2'b00};
        exp_pc  = {tgt[31:2], 2'b00};
      end
      n_checks++;
      if (((exp_req - exp_pc) >> 2) > 32'd4) begin
        n_fail++; $display("FAIL rnd_credit[%0d]: got %0d live expected <=4", c, (exp_req - exp_pc) >> 2);
      end
      prev_pend = !do_redir && mif.imem_req_valid && !mif.imem_req_ready;
      prev_addr = mif.imem_req_addr;
    end
    redirect = 1'b0;
    n_checks++;
    if (hs_drain < 20) begin n_fail++; $display("FAIL rnd_drain: got %0d handshakes expected >=20", hs_drain); end
  endtask

  task automatic test_stall_reset;
    logic [31:0] held;
    @(posedge clk); #1;
    redirect = 1'b0; mif.id_ready = 1'b1; mem_mode = 1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (mif.imem_req_valid !== 1'b1 || mif.imem_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_setup: got v=%b r=%b expected v=1 r=0", mif.imem_req_valid, mif.imem_req_ready);
    end
    held = mif.imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== held) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b a=%h expected v=1 a=%h", i, mif.imem_req_valid, mif.imem_req_addr, held);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mif.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_rst_now: got %b expected 0", mif.imem_req_valid); end
    @(negedge clk);
    n_checks++;
    if (mif.imem_req_valid !== 1'b0 || mif.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_rst_next: got req=%b id=%b expected 0 0", mif.imem_req_valid, mif.id_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_mode = 0;
    @(negedge clk);
    n_checks++;
    if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL stall_restart: got v=%b a=%h expected v=1 a=00000000", mif.imem_req_valid, mif.imem_req_addr);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_a;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wif.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_rst: got %b expected 0", wif.imem_req_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_a = 32'hFFFF_FFF8 + 32'(4*i);
      n_checks++;
      if (wif.imem_req_valid !== 1'b1 || wif.imem_req_addr !== exp_a) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got v=%b a=%h expected v=1 a=%h", i, wif.imem_req_valid, wif.imem_req_addr, exp_a);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    mif.id_ready = 1'b0;
    wif.imem_req_ready = 1'b1;
    wif.imem_rsp_valid = 1'b0;
    wif.imem_rsp_data = '0;
    wif.id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_random();
    test_stall_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
